// File: rtl/mem_access.sv
// MIPS memory-access stage: EX/MEM register, data-SRAM handshake, store lane formatting, load extension.
// Latency: one cycle for non-memory ops; loads/stores hold mem_stall for >=2 cycles (REQ, then WAIT).
// Backpressure: REQ waits on data_addr_ok and WAIT waits on data_data_ok; mem_stall freezes the pipe meanwhile.
module mem_access #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [1:0]        mem_size_in,
  input  logic              mem_unsigned_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic [4:0]        write_addr_in,
  input  logic [31:0]       inst_in,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [DATA_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [4:0]        write_addr_out,
  output logic [DATA_W-1:0] write_data_alu,
  output logic [DATA_W-1:0] write_data_mem,
  output logic              reg_write_final,
  output logic              mem_to_reg_final,
  output logic [31:0]       inst_out,
  output logic              mem_stall,
  output logic              addr_err_load,
  output logic              addr_err_store
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Byte accesses never fault; halves need an even address; words (and the reserved size) need 4-byte alignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a[0];
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   alu_result_q, alu_result_d;
  logic [DATA_W-1:0]   store_data_q, store_data_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [1:0]          mem_size_q, mem_size_d;
  logic                mem_unsigned_q, mem_unsigned_d;
  logic                reg_write_q, reg_write_d;
  logic                mem_to_reg_q, mem_to_reg_d;
  logic [4:0]          write_addr_q, write_addr_d;
  logic [31:0]         inst_q, inst_d;

  logic                mis_q;
  logic                in_mem_ok;
  logic [DATA_W-1:0]   rshift;
  logic [DATA_W-1:0]   load_ext;

  // EX/MEM register: capture everything from execute unless the pipeline is stalled.
  always_comb begin
    alu_result_d   = alu_result_q;
    store_data_d   = store_data_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    mem_size_d     = mem_size_q;
    mem_unsigned_d = mem_unsigned_q;
    reg_write_d    = reg_write_q;
    mem_to_reg_d   = mem_to_reg_q;
    write_addr_d   = write_addr_q;
    inst_d         = inst_q;
    if (!stall) begin
      alu_result_d   = alu_result_in;
      store_data_d   = store_data_in;
      mem_read_d     = mem_read_in;
      mem_write_d    = mem_write_in;
      mem_size_d     = mem_size_in;
      mem_unsigned_d = mem_unsigned_in;
      reg_write_d    = reg_write_in;
      mem_to_reg_d   = mem_to_reg_in;
      write_addr_d   = write_addr_in;
      inst_d         = inst_in;
    end
  end

  // Only an aligned load/store entering the stage starts a bus transaction.
  assign in_mem_ok = (mem_read_in | mem_write_in) & ~misaligned(mem_size_in, alu_result_in[1:0]);

  // Bus FSM next state; read data is captured on the data_data_ok beat.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      REQ: begin
        if (data_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (data_data_ok) begin
          state_d = DONE;
          rdata_d = data_rdata;
        end
      end
      default: state_d = state_q;
    endcase
    if (!stall) state_d = in_mem_ok ? REQ : IDLE;
  end

  // State and pipeline flops; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      alu_result_q   <= '0;
      store_data_q   <= '0;
      rdata_q        <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_size_q     <= 2'b00;
      mem_unsigned_q <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      write_addr_q   <= '0;
      inst_q         <= '0;
    end else begin
      state_q        <= state_d;
      alu_result_q   <= alu_result_d;
      store_data_q   <= store_data_d;
      rdata_q        <= rdata_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_size_q     <= mem_size_d;
      mem_unsigned_q <= mem_unsigned_d;
      reg_write_q    <= reg_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      write_addr_q   <= write_addr_d;
      inst_q         <= inst_d;
    end
  end

  assign mis_q          = misaligned(mem_size_q, alu_result_q[1:0]);
  assign addr_err_load  = mem_read_q & mis_q;
  assign addr_err_store = mem_write_q & mis_q;
  assign mem_stall      = (state_q == REQ) || (state_q == WAIT);

  // Request fields come straight from the latched stage, so they cannot move while data_req is high.
  assign data_req  = (state_q == REQ);
  assign data_wr   = mem_write_q;
  assign data_size = mem_size_q;
  assign data_addr = alu_result_q;

  // Store lane replication and byte strobes (little-endian); loads drive no strobes.
  always_comb begin
    data_wdata = store_data_q;
    data_wstrb = 4'b0000;
    case (mem_size_q)
      2'b00: begin
        data_wdata = {4{store_data_q[7:0]}};
        data_wstrb = 4'b0001 << alu_result_q[1:0];
      end
      2'b01: begin
        data_wdata = {2{store_data_q[15:0]}};
        data_wstrb = 4'b0011 << alu_result_q[1:0];
      end
      default: begin
        data_wdata = store_data_q;
        data_wstrb = 4'b1111;
      end
    endcase
    if (!mem_write_q) data_wstrb = 4'b0000;
  end

  assign rshift = rdata_q >> {alu_result_q[1:0], 3'b000};

  // Load extension from the captured read word, selected by latched size/offset/unsigned.
  always_comb begin
    load_ext = rdata_q;
    case (mem_size_q)
      2'b00:   load_ext = mem_unsigned_q ? {24'h000000, rshift[7:0]}
                                         : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   load_ext = mem_unsigned_q ? {16'h0000, rshift[15:0]}
                                         : {{16{rshift[15]}}, rshift[15:0]};
      default: load_ext = rdata_q;
    endcase
  end

  assign write_data_mem   = mem_read_q ? load_ext : '0;
  assign write_data_alu   = alu_result_q;
  assign write_addr_out   = write_addr_q;
  assign inst_out         = inst_q;
  assign reg_write_final  = reg_write_q & ~mem_stall & ~(addr_err_load | addr_err_store);
  assign mem_to_reg_final = mem_to_reg_q & mem_read_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: vector table of loads/stores/ALU ops with a bus responder and scoreboard.
// Hand sequences cover the stall-hold behaviour and reset during an outstanding access.
// The hazard-unit OR of mem_stall into stall is modelled here.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall_drv;
  logic        stall;
  logic [31:0] alu_result_in, store_data_in, inst_in;
  logic        mem_read_in, mem_write_in, mem_unsigned_in, reg_write_in, mem_to_reg_in;
  logic [1:0]  mem_size_in;
  logic [4:0]  write_addr_in;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [4:0]  write_addr_out;
  logic [31:0] write_data_alu, write_data_mem, inst_out;
  logic        reg_write_final, mem_to_reg_final, mem_stall, addr_err_load, addr_err_store;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign stall = stall_drv | mem_stall;

  mem_access #(.DATA_W(32)) dut (
    .clk(clk), .rstn(rstn), .stall(stall),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .write_addr_in(write_addr_in), .inst_in(inst_in),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .write_addr_out(write_addr_out), .write_data_alu(write_data_alu),
    .write_data_mem(write_data_mem), .reg_write_final(reg_write_final),
    .mem_to_reg_final(mem_to_reg_final), .inst_out(inst_out),
    .mem_stall(mem_stall), .addr_err_load(addr_err_load), .addr_err_store(addr_err_store)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic        rw;
    logic        m2r;
    int          addr_dly;
    int          data_dly;
    logic [31:0] rdata;
    int          e_req;
    int          e_stall;
    logic [31:0] e_wdm;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic        e_rwf;
    logic        e_errl;
    logic        e_errs;
  } vec_t;

  vec_t vecs[14];
  vec_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t        e;
    int          req_cnt, stall_cnt, wait_cnt, cyc;
    logic        rwf_bad, unstable;
    logic [31:0] a0, wd0;
    logic [3:0]  strb0;
    logic [1:0]  size0;
    logic        wr0;
    @(negedge clk);
    alu_result_in   = v.alu;
    store_data_in   = v.sd;
    mem_read_in     = v.rd;
    mem_write_in    = v.wr;
    mem_size_in     = v.size;
    mem_unsigned_in = v.uns;
    reg_write_in    = v.rw;
    mem_to_reg_in   = v.m2r;
    write_addr_in   = 5'(idx + 1);
    inst_in         = 32'hA000_0000 | 32'(idx);
    stall_drv       = 1'b0;
    data_addr_ok    = 1'b0;
    data_data_ok    = 1'b0;
    sb_q.push_back(v);
    @(negedge clk);
    stall_drv = 1'b1;
    a0 = data_addr; wd0 = data_wdata; strb0 = data_wstrb; size0 = data_size; wr0 = data_wr;
    req_cnt = 0; stall_cnt = 0; wait_cnt = 0; cyc = 0; rwf_bad = 1'b0; unstable = 1'b0;
    while (mem_stall && cyc < 60) begin
      cyc++;
      stall_cnt++;
      if (reg_write_final) rwf_bad = 1'b1;
      if (data_req) begin
        req_cnt++;
        if (data_addr !== a0 || data_wdata !== wd0 || data_wstrb !== strb0 ||
            data_size !== size0 || data_wr !== wr0) unstable = 1'b1;
        data_addr_ok = (req_cnt > v.addr_dly);
        data_data_ok = 1'b0;
      end else begin
        wait_cnt++;
        data_addr_ok = 1'b0;
        data_data_ok = (wait_cnt > v.data_dly);
        data_rdata   = v.rdata;
      end
      @(negedge clk);
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    chk($sformatf("v%0d timeout", idx), 32'(cyc >= 60), 32'd0);
    e = sb_q.pop_front();
    chk($sformatf("v%0d req_cycles", idx), 32'(req_cnt), 32'(e.e_req));
    chk($sformatf("v%0d stall_cycles", idx), 32'(stall_cnt), 32'(e.e_stall));
    chk($sformatf("v%0d rwf_during_stall", idx), 32'(rwf_bad), 32'd0);
    chk($sformatf("v%0d req_stable", idx), 32'(unstable), 32'd0);
    chk($sformatf("v%0d reg_write_final", idx), 32'(reg_write_final), 32'(e.e_rwf));
    chk($sformatf("v%0d addr_err_load", idx), 32'(addr_err_load), 32'(e.e_errl));
    chk($sformatf("v%0d addr_err_store", idx), 32'(addr_err_store), 32'(e.e_errs));
    chk($sformatf("v%0d write_data_alu", idx), write_data_alu, e.alu);
    chk($sformatf("v%0d write_addr_out", idx), 32'(write_addr_out), 32'(idx + 1));
    chk($sformatf("v%0d inst_out", idx), inst_out, 32'hA000_0000 | 32'(idx));
    chk($sformatf("v%0d mem_to_reg_final", idx), 32'(mem_to_reg_final), 32'(e.m2r & e.rd));
    chk($sformatf("v%0d data_wr", idx), 32'(wr0), 32'(e.wr));
    if (!e.e_errl && !e.e_errs) begin
      chk($sformatf("v%0d write_data_mem", idx), write_data_mem, e.e_wdm);
      chk($sformatf("v%0d data_wstrb", idx), 32'(strb0), 32'(e.e_strb));
      chk($sformatf("v%0d data_size", idx), 32'(size0), 32'(e.size));
    end
    if (e.wr && !e.e_errs) chk($sformatf("v%0d data_wdata", idx), wd0, e.e_wdata);
  endtask

  initial begin
    //          alu           sd            rd wr size  uns rw m2r ad dd rdata         req stl e_wdm         strb     e_wdata       rwf el es
    vecs[0]  = '{32'h100, 32'h0,        1, 0, 2'd2, 0, 1, 1, 2, 0, 32'hDEADBEEF, 3, 4, 32'hDEADBEEF, 4'b0000, 32'h0,        1, 0, 0};
    vecs[1]  = '{32'h103, 32'h0,        1, 0, 2'd0, 0, 1, 1, 0, 0, 32'h80123456, 1, 2, 32'hFFFFFF80, 4'b0000, 32'h0,        1, 0, 0};
    vecs[2]  = '{32'h103, 32'h0,        1, 0, 2'd0, 1, 1, 1, 0, 0, 32'h80123456, 1, 2, 32'h00000080, 4'b0000, 32'h0,        1, 0, 0};
    vecs[3]  = '{32'h102, 32'h0,        1, 0, 2'd1, 0, 1, 1, 0, 0, 32'h80123456, 1, 2, 32'hFFFF8012, 4'b0000, 32'h0,        1, 0, 0};
    vecs[4]  = '{32'h100, 32'h0,        1, 0, 2'd1, 1, 1, 1, 0, 0, 32'h80128765, 1, 2, 32'h00008765, 4'b0000, 32'h0,        1, 0, 0};
    vecs[5]  = '{32'h100, 32'h0,        1, 0, 2'd0, 0, 1, 1, 1, 1, 32'h1234567F, 2, 4, 32'h0000007F, 4'b0000, 32'h0,        1, 0, 0};
    vecs[6]  = '{32'h202, 32'h0000ABCD, 0, 1, 2'd1, 0, 0, 0, 0, 0, 32'h0,        1, 2, 32'h0,        4'b1100, 32'hABCDABCD, 0, 0, 0};
    vecs[7]  = '{32'h201, 32'h000000A5, 0, 1, 2'd0, 0, 0, 0, 0, 0, 32'h0,        1, 2, 32'h0,        4'b0010, 32'hA5A5A5A5, 0, 0, 0};
    vecs[8]  = '{32'h200, 32'h12345678, 0, 1, 2'd2, 0, 0, 0, 1, 1, 32'h0,        2, 4, 32'h0,        4'b1111, 32'h12345678, 0, 0, 0};
    vecs[9]  = '{32'h006, 32'h0,        1, 0, 2'd2, 0, 1, 1, 0, 0, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        0, 1, 0};
    vecs[10] = '{32'h001, 32'h11111111, 0, 1, 2'd2, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        0, 0, 1};
    vecs[11] = '{32'h101, 32'h0,        1, 0, 2'd1, 0, 1, 1, 0, 0, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        0, 1, 0};
    vecs[12] = '{32'h055, 32'h0,        0, 0, 2'd0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1, 0, 0};
    vecs[13] = '{32'h104, 32'h0,        1, 0, 2'd3, 0, 1, 1, 0, 2, 32'hCAFEF00D, 1, 4, 32'hCAFEF00D, 4'b0000, 32'h0,        1, 0, 0};

    rstn = 1'b0; stall_drv = 1'b1;
    alu_result_in = '0; store_data_in = '0; inst_in = '0;
    mem_read_in = 0; mem_write_in = 0; mem_size_in = 2'd0; mem_unsigned_in = 0;
    reg_write_in = 0; mem_to_reg_in = 0; write_addr_in = '0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst data_req", 32'(data_req), 32'd0);
    chk("rst mem_stall", 32'(mem_stall), 32'd0);
    chk("rst write_data_alu", write_data_alu, 32'd0);
    chk("rst write_data_mem", write_data_mem, 32'd0);
    chk("rst data_addr", data_addr, 32'd0);
    chk("rst data_wdata", data_wdata, 32'd0);
    chk("rst ctrl", {data_wstrb, data_size, data_wr, reg_write_final, mem_to_reg_final,
                     addr_err_load, addr_err_store, write_addr_out}, 32'd0);
    chk("rst inst_out", inst_out, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // ALU op followed by a global stall: the latched fields must hold.
    @(negedge clk);
    alu_result_in = 32'h55; mem_read_in = 0; mem_write_in = 0; reg_write_in = 1;
    mem_to_reg_in = 0; write_addr_in = 5'd7; inst_in = 32'h00A51021; stall_drv = 1'b0;
    @(negedge clk);
    chk("addu write_data_alu", write_data_alu, 32'h55);
    chk("addu reg_write_final", 32'(reg_write_final), 32'd1);
    chk("addu mem_stall", 32'(mem_stall), 32'd0);
    stall_drv = 1'b1;
    alu_result_in = 32'h99; write_addr_in = 5'd9; inst_in = 32'h12345678; reg_write_in = 0;
    repeat (2) @(negedge clk);
    chk("hold write_data_alu", write_data_alu, 32'h55);
    chk("hold write_addr_out", 32'(write_addr_out), 32'd7);
    chk("hold inst_out", inst_out, 32'h00A51021);
    chk("hold reg_write_final", 32'(reg_write_final), 32'd1);

    // Reset while a load sits in WAIT; a late data_data_ok must be ignored.
    alu_result_in = 32'h300; mem_read_in = 1; mem_size_in = 2'd2; reg_write_in = 1;
    mem_to_reg_in = 1; write_addr_in = 5'd3; inst_in = 32'h8C000300; stall_drv = 1'b0;
    @(negedge clk);
    stall_drv = 1'b1;
    chk("rw req", 32'(data_req), 32'd1);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    chk("rw in_wait", {30'd0, mem_stall, data_req}, 32'd2);
    #2 rstn = 1'b0;
    #1;
    chk("rw data_req", 32'(data_req), 32'd0);
    chk("rw mem_stall", 32'(mem_stall), 32'd0);
    chk("rw write_data_alu", write_data_alu, 32'd0);
    chk("rw data_addr", data_addr, 32'd0);
    chk("rw ctrl", {data_wstrb, data_size, data_wr, reg_write_final, mem_to_reg_final,
                    addr_err_load, addr_err_store, write_addr_out}, 32'd0);
    chk("rw inst_out", inst_out, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    data_data_ok = 1'b1; data_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    data_data_ok = 1'b0;
    chk("late ok mem_stall", 32'(mem_stall), 32'd0);
    chk("late ok data_req", 32'(data_req), 32'd0);
    chk("late ok write_data_mem", write_data_mem, 32'd0);
    chk("late ok reg_write_final", 32'(reg_write_final), 32'd0);
    @(negedge clk);
    chk("late ok idle", {30'd0, mem_stall, data_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
